// File: rtl/seg7_pkg.sv
// Seven-segment glyphs, FSM states and BCD decoder
// shared by the signed display driver slice.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    UPDATE  = 2'd2
  } state_t;

  function automatic logic [6:0] bcd_to_seg(
    input logic [3:0] nibble
  );
    logic [6:0] s;
    case (nibble)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial shift-add-3 converter: 8-bit binary to
// three BCD digits, one iteration per clock.
module bin2bcd_serial
  import seg7_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd
);

  logic [11:0] bcd_q;
  logic [11:0] adj;
  logic [7:0]  bin_q;
  logic [2:0]  cnt_q;
  logic        run_q;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5)
        adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q <= '0;
      bin_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      bcd_q <= '0;
      bin_q <= bin;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      {bcd_q, bin_q} <= {adj[10:0], bin_q, 1'b0};
      cnt_q <= cnt_q + 3'd1;
      if (cnt_q == 3'd7)
        run_q <= 1'b0;
    end
  end

  // done marks the edge performing the 8th iteration
  assign done = run_q && (cnt_q == 3'd7);
  assign busy = run_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/signed_display_driver.sv
// Captures a signed byte, converts its magnitude to BCD
// and scans sign/hundreds/tens/ones on a 4-digit display.
module signed_display_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] value,
  input  logic       load,
  output logic       busy,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int CW = $clog2(REFRESH_DIV);

  state_t        state_q;
  logic          sign_q;
  logic          start;
  logic [7:0]    mag;
  logic          conv_busy;
  logic          conv_done;
  logic [11:0]   bcd;

  logic          d_sign;
  logic [3:0]    d_hund;
  logic [3:0]    d_tens;
  logic [3:0]    d_ones;

  logic [CW-1:0] ref_q;
  logic [1:0]    dig_q;
  logic [6:0]    seg_d;
  logic [3:0]    an_d;
  logic [6:0]    seg_q;
  logic [3:0]    an_q;

  assign start = (state_q == IDLE) && load;
  assign mag   = value[7] ? (~value + 8'd1) : value;

  bin2bcd_serial u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (mag),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (bcd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      d_sign  <= 1'b0;
      d_hund  <= '0;
      d_tens  <= '0;
      d_ones  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load) begin
            sign_q  <= value[7];
            state_q <= CONVERT;
          end
        end
        CONVERT: begin
          if (conv_done)
            state_q <= UPDATE;
        end
        UPDATE: begin
          d_sign  <= sign_q;
          d_hund  <= bcd[11:8];
          d_tens  <= bcd[7:4];
          d_ones  <= bcd[3:0];
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_q <= '0;
      dig_q <= '0;
    end else if (ref_q == CW'(REFRESH_DIV - 1)) begin
      ref_q <= '0;
      dig_q <= dig_q + 2'd1;
    end else begin
      ref_q <= ref_q + CW'(1);
    end
  end

  // leading zeros are blanked; the ones digit always shows
  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = 4'b1111;
    unique case (dig_q)
      2'd0: begin
        an_d  = 4'b1110;
        seg_d = bcd_to_seg(d_ones);
      end
      2'd1: begin
        an_d = 4'b1101;
        if (d_hund != 4'd0 || d_tens != 4'd0)
          seg_d = bcd_to_seg(d_tens);
      end
      2'd2: begin
        an_d = 4'b1011;
        if (d_hund != 4'd0)
          seg_d = bcd_to_seg(d_hund);
      end
      default: begin
        an_d  = 4'b0111;
        seg_d = d_sign ? SEG_MINUS : SEG_BLANK;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEG_BLANK;
      an_q  <= 4'b1111;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign busy = conv_busy || (state_q != IDLE);
  assign seg  = seg_q;
  assign an   = an_q;
  assign dp   = 1'b1;

endmodule

// File: doc/signed_display_driver.md
# signed_display_driver

Downstream consumer of the 8-bit two's-complement negator. It captures a signed 8-bit result and converts its magnitude to BCD with a sequential shift-add-3 engine. It then drives a time-multiplexed 4-digit active-low seven-segment display as sign, hundreds, tens and ones, so the lab board can show values from -128 to +127 in decimal.

## Interface

- REFRESH_DIV, 100000: clock cycles each digit stays lit; legal range ≥2.
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- value  input  8  signed two's-complement operand.
- load  input  1  request to capture `value`; level-sampled.
- busy  output  1  high while a conversion is in progress.
- seg  output  7  segment cathodes, active-low, bit order {g,f,e,d,c,b,a}.
- an  output  4  digit anodes, active-low, one-hot; an[0] = ones, an[3] = sign.
- dp  output  1  decimal point, active-low; constant 1 (off).

## Operation

- FSM states: IDLE, CONVERT, UPDATE. Reset state: IDLE.
- IDLE:
  - If load=1 at a clock edge: capture sign = value[7] and mag = value[7] ? (~value + 1) : value, as an 8-bit unsigned value.
  - -128 (8'h80) yields mag = 128.
  - Clear the BCD shift register (12 bits), set the iteration count to 0, and go to CONVERT.
- CONVERT: one iteration per cycle, 8 iterations.
  - Each iteration first adds 3 to every BCD nibble ≥5.
  - It then shifts {bcd, mag} left by 1.
  - After the 8th iteration, go to UPDATE.
- UPDATE:
  - Copy the hundreds, tens, ones and sign into the display registers atomically, then return to IDLE.
  - The display registers change only in this state, so a partially converted value is never shown.
- load while in CONVERT or UPDATE is ignored. load held high re-triggers a new capture on the first IDLE edge.
- Digit content:
  - an[3]: minus (0111111) if sign=1, else blank (1111111).
  - an[2]: hundreds digit; blank if hundreds = 0.
  - an[1]: tens digit; blank if hundreds = 0 and tens = 0.
  - an[0]: ones digit, always shown.
- Glyphs, active-low gfedcba:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
- Scan:
  - A refresh counter counts 0 to REFRESH_DIV-1.
  - On wrap, the 2-bit digit index advances 0→1→2→3→0.
- Reset values:
  - Outputs: busy=0, seg=1111111, an=1111, dp=1.
  - Internal: display registers 0, sign=0, refresh counter 0, digit index 0.

## Timing

- load sampled at edge k in IDLE: busy=1 after edge k.
- CONVERT occupies edges k+1 through k+8.
- UPDATE occurs at edge k+9: display registers load and busy=0 after that edge.
- Conversion latency is 9 cycles, and the earliest next capture is edge k+10.
- seg/an are registered: they reflect the digit index and display registers of the previous cycle, a 1-cycle lag.
- First cycle after reset: an=1110 and seg=1000000 (shows "0").
- If UPDATE and a refresh wrap happen on the same edge, both take effect. The new digit shows new data one cycle later.
- An rst_n assertion mid-CONVERT aborts the conversion immediately: busy=0 and the display registers clear.

## Structure

- Package `seg7_pkg`:
  - Glyph constants SEG_0 through SEG_9, SEG_BLANK and SEG_MINUS.
  - FSM state enum.
  - Function `bcd_to_seg(nibble)`.
- Sub-module `bin2bcd_serial`: the 8-bit to 3-digit shift-add-3 engine with start/busy/done, holding the CONVERT datapath.
- The top level holds the capture and negate logic, the UPDATE registers, the refresh counter and the digit mux.

## Test plan

All scenarios run with REFRESH_DIV=4.

- Reset: rst_n low → busy=0, an=1111, seg=1111111. First edge after release → an=1110, seg=1000000.
- value=8'd123, load 1 cycle → busy high exactly 9 cycles. The scan then shows:
  - an[0] = 0110000
  - an[1] = 0100100
  - an[2] = 1111001
  - an[3] = 1111111
- value=8'hFB (-5) → an[3] = 0111111, an[2] and an[1] blank, an[0] = 0010010.
- value=8'h80 → -128: minus, 1111001, 0100100, 0000000. value=8'h7F → blank, 1, 2, 7.
- load=8'd9, then at busy cycle 3 change value to 8'd50 with load=1 → display shows 9. With load held, it shows 50 after the next 9-cycle conversion.
- Display 8'd42, then load 8'd7 and assert rst_n at CONVERT cycle 4 → busy=0 and an=1111 immediately. After release the display shows 0, not 42 or 7.
